// File: rtl/conv2d_stream.sv
// conv2d_stream
//   Streaming multi-channel KxK convolver. Accepts one activation pixel per
//   ready/valid handshake in raster order over an NxN frame. It keeps the
//   previous K-1 rows in line buffers and a KxK window of the newest K
//   columns. It emits M parallel dot products (one per output channel)
//   through a single output register with backpressure.
//
//   Optional build macro: CONV_RELU_EN
//     defined   -> each channel result is clamped to 0 when negative
//     undefined -> raw signed sums truncated to OW bits
//
// Ports
//   clk          clock, rising edge
//   global_rst   synchronous active-high reset
//   in_valid     activation beat valid
//   in_ready     block accepts a beat this cycle
//   activation   signed pixel, DW bits
//   weights      kernel m tap (i,j) at [((m*K+i)*K+j)*DW +: DW]
//   conv_op      channel m result at [m*OW +: OW]
//   valid_conv   output beat valid
//   conv_ready   downstream accepts output
//   end_conv     marks the last output beat of a frame
module conv2d_stream #(
  parameter int DW = 16,
  parameter int N  = 6,
  parameter int K  = 5,
  parameter int S  = 1,
  parameter int M  = 1,
  parameter int OW = 32
) (
  input  logic                  clk,
  input  logic                  global_rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DW-1:0]         activation,
  input  logic [M*K*K*DW-1:0]   weights,
  output logic [M*OW-1:0]       conv_op,
  output logic                  valid_conv,
  input  logic                  conv_ready,
  output logic                  end_conv
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  // Sum width large enough that K*K full products never overflow before
  // the final truncation to OW.
  localparam int SW = 2*DW + $clog2(K*K) + 1;
  localparam int AW = (SW > OW) ? SW : OW;
  localparam logic [CW-1:0] LAST = CW'(N-1);

  logic [CW-1:0]          row_cnt;
  logic [CW-1:0]          col_cnt;
  logic                   accept;
  logic                   complete;
  logic                   frame_end;
  logic [31:0]            row_off;
  logic [31:0]            col_off;

  // line_buf[i][c] holds row (r-K+1+i) at column c, i.e. index 0 is oldest.
  logic signed [DW-1:0]   line_buf [K-1][N];
  logic signed [DW-1:0]   win      [K][K];
  logic signed [DW-1:0]   col_new  [K];
  logic signed [DW-1:0]   win_next [K][K];

  logic signed [DW-1:0]   w_raw;
  logic signed [AW-1:0]   w_ext;
  logic signed [AW-1:0]   x_ext;
  logic signed [AW-1:0]   acc;
  logic [OW-1:0]          trunc;
  logic [M*OW-1:0]        result;

  assign in_ready  = !valid_conv || conv_ready;
  assign accept    = in_valid && in_ready;
  assign frame_end = (row_cnt == LAST) && (col_cnt == LAST);

  // Column entering the window: K-1 buffered pixels above plus the new one.
  always_comb begin
    for (int i = 0; i < K-1; i++) begin
      col_new[i] = line_buf[i][col_cnt];
    end
    col_new[K-1] = activation;
  end

  always_comb begin
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K-1; j++) begin
        win_next[i][j] = win[i][j+1];
      end
      win_next[i][K-1] = col_new[i];
    end
  end

  always_comb begin
    row_off  = 32'(row_cnt) - 32'(K-1);
    col_off  = 32'(col_cnt) - 32'(K-1);
    complete = (32'(row_cnt) >= 32'(K-1)) && (32'(col_cnt) >= 32'(K-1)) &&
               ((row_off % 32'(S)) == 32'd0) && ((col_off % 32'(S)) == 32'd0);
  end

  // Dot products over the window as it will look after this acceptance.
  always_comb begin
    result = '0;
    w_raw  = '0;
    w_ext  = '0;
    x_ext  = '0;
    acc    = '0;
    trunc  = '0;
    for (int m = 0; m < M; m++) begin
      acc = '0;
      for (int i = 0; i < K; i++) begin
        for (int j = 0; j < K; j++) begin
          w_raw = weights[((m*K+i)*K+j)*DW +: DW];
          w_ext = AW'(w_raw);
          x_ext = AW'(win_next[i][j]);
          acc   = acc + w_ext * x_ext;
        end
      end
      trunc = acc[OW-1:0];
`ifdef CONV_RELU_EN
      if (trunc[OW-1]) begin
        trunc = '0;
      end
`endif
      result[m*OW +: OW] = trunc;
    end
  end

  always_ff @(posedge clk) begin
    if (global_rst) begin
      row_cnt    <= '0;
      col_cnt    <= '0;
      valid_conv <= 1'b0;
      end_conv   <= 1'b0;
      conv_op    <= '0;
    end else begin
      if (accept) begin
        if (col_cnt == LAST) begin
          col_cnt <= '0;
          row_cnt <= (row_cnt == LAST) ? '0 : row_cnt + CW'(1);
        end else begin
          col_cnt <= col_cnt + CW'(1);
        end
      end
      if (accept && complete) begin
        conv_op    <= result;
        valid_conv <= 1'b1;
        end_conv   <= frame_end;
      end else if (conv_ready) begin
        valid_conv <= 1'b0;
        end_conv   <= 1'b0;
      end
    end
  end

  // Buffer contents need no reset: no window completes before K-1 fresh
  // rows have been written after the counters restart at (0,0).
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < K-1; i++) begin
        line_buf[i][col_cnt] <= col_new[i+1];
      end
      win <= win_next;
    end
  end

endmodule

// File: tb/tb_conv2d_stream.sv
// Testbench for conv2d_stream: three instances (N6/K5/S1/M1, N7/K3/S2/M1,
// N6/K5/S1/M2) driven with directed vectors and hand-computed results.
module tb_conv2d_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // Instance A: N=6 K=5 S=1 M=1
  logic              a_in_valid, a_in_ready, a_conv_ready, a_valid, a_end;
  logic [15:0]       a_act;
  logic [25*16-1:0]  a_w;
  logic [31:0]       a_op;

  // Instance B: N=7 K=3 S=2 M=1
  logic              b_in_valid, b_in_ready, b_conv_ready, b_valid, b_end;
  logic [15:0]       b_act;
  logic [9*16-1:0]   b_w;
  logic [31:0]       b_op;

  // Instance C: N=6 K=5 S=1 M=2
  logic              c_in_valid, c_in_ready, c_conv_ready, c_valid, c_end;
  logic [15:0]       c_act;
  logic [50*16-1:0]  c_w;
  logic [63:0]       c_op;

  conv2d_stream #(.DW(16), .N(6), .K(5), .S(1), .M(1), .OW(32)) dut_a (
    .clk(clk), .global_rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .activation(a_act), .weights(a_w), .conv_op(a_op), .valid_conv(a_valid),
    .conv_ready(a_conv_ready), .end_conv(a_end));

  conv2d_stream #(.DW(16), .N(7), .K(3), .S(2), .M(1), .OW(32)) dut_b (
    .clk(clk), .global_rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .activation(b_act), .weights(b_w), .conv_op(b_op), .valid_conv(b_valid),
    .conv_ready(b_conv_ready), .end_conv(b_end));

  conv2d_stream #(.DW(16), .N(6), .K(5), .S(1), .M(2), .OW(32)) dut_c (
    .clk(clk), .global_rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .activation(c_act), .weights(c_w), .conv_op(c_op), .valid_conv(c_valid),
    .conv_ready(c_conv_ready), .end_conv(c_end));

  typedef struct {
    logic [15:0] act;
    logic        exp_valid;
    logic [31:0] exp_op;
    logic        exp_end;
  } vec_t;

  vec_t tab_a [36];
  vec_t tab_b [49];

  int n_cmp = 0;
  int n_bad = 0;
  int n_out;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Present beat k of table A, let it be accepted, then check the output.
  task automatic a_beat(input int k, input string tag);
    a_in_valid = 1'b1;
    a_act      = tab_a[k].act;
    @(posedge clk);
    #1;
    if (a_valid) n_out++;
    chk($sformatf("%s_valid_b%0d", tag, k), 64'(a_valid), 64'(tab_a[k].exp_valid));
    if (tab_a[k].exp_valid) begin
      chk($sformatf("%s_op_b%0d", tag, k), 64'(a_op), 64'(tab_a[k].exp_op));
      chk($sformatf("%s_end_b%0d", tag, k), 64'(a_end), 64'(tab_a[k].exp_end));
    end
  endtask

  initial begin
    // Expected tables
    for (int k = 0; k < 36; k++) tab_a[k] = '{16'(k), 1'b0, 32'd0, 1'b0};
    tab_a[28] = '{16'd28, 1'b1, 32'd5750, 1'b0};
    tab_a[29] = '{16'd29, 1'b1, 32'd6050, 1'b0};
    tab_a[34] = '{16'd34, 1'b1, 32'd7550, 1'b0};
    tab_a[35] = '{16'd35, 1'b1, 32'd7850, 1'b1};
    for (int k = 0; k < 49; k++) begin
      int r, c;
      logic v;
      r = k / 7;
      c = k % 7;
      v = (r >= 2) && (c >= 2) && (r % 2 == 0) && (c % 2 == 0);
      // all-ones 3x3 kernel: sum = 9 * centre pixel
      tab_b[k] = '{16'(k), v, v ? 32'(9 * (7*(r-1) + (c-1))) : 32'd0, (r == 6) && (c == 6)};
    end

    // Weights
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++) begin
        a_w[(i*5+j)*16 +: 16]      = 16'(5*i + j);
        c_w[(i*5+j)*16 +: 16]      = 16'd1;
        c_w[((5+i)*5+j)*16 +: 16]  = 16'hFFFF;
      end
    for (int t = 0; t < 9; t++) b_w[t*16 +: 16] = 16'd1;

    a_in_valid = 0; a_act = 0; a_conv_ready = 1;
    b_in_valid = 0; b_act = 0; b_conv_ready = 1;
    c_in_valid = 0; c_act = 0; c_conv_ready = 1;

    // Reset state
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_valid", 64'(a_valid), 64'd0);
    chk("rst_end",   64'(a_end),   64'd0);
    chk("rst_op",    64'(a_op),    64'd0);
    chk("rst_ready", 64'(a_in_ready), 64'd1);
    rst = 1'b0;

    // Two back-to-back frames, no gap
    n_out = 0;
    for (int f = 0; f < 2; f++)
      for (int k = 0; k < 36; k++) a_beat(k, $sformatf("a_f%0d", f));
    chk("a_two_frame_count", 64'(n_out), 64'd8);

    // Backpressure on the first output of a frame
    for (int k = 0; k < 29; k++) a_beat(k, "bp_pre");
    a_conv_ready = 1'b0;
    a_act        = 16'd29;
    for (int s = 0; s < 3; s++) begin
      @(posedge clk);
      #1;
      chk($sformatf("bp_ready_s%0d", s), 64'(a_in_ready), 64'd0);
      chk($sformatf("bp_valid_s%0d", s), 64'(a_valid),    64'd1);
      chk($sformatf("bp_op_s%0d", s),    64'(a_op),       64'd5750);
      chk($sformatf("bp_end_s%0d", s),   64'(a_end),      64'd0);
    end
    a_conv_ready = 1'b1;
    for (int k = 29; k < 36; k++) a_beat(k, "bp_post");

    // Reset mid-frame, then a full frame
    for (int k = 0; k < 20; k++) a_beat(k, "mr_pre");
    a_in_valid = 1'b0;
    rst = 1'b1;
    for (int s = 0; s < 2; s++) begin
      @(posedge clk);
      #1;
      chk($sformatf("mr_valid_s%0d", s), 64'(a_valid), 64'd0);
    end
    rst = 1'b0;
    for (int k = 0; k < 36; k++) a_beat(k, "mr_post");
    a_in_valid = 1'b0;

    // Stride 2, 3x3 kernel on a 7x7 frame
    n_out = 0;
    for (int k = 0; k < 49; k++) begin
      b_in_valid = 1'b1;
      b_act      = tab_b[k].act;
      @(posedge clk);
      #1;
      if (b_valid) n_out++;
      chk($sformatf("b_valid_b%0d", k), 64'(b_valid), 64'(tab_b[k].exp_valid));
      if (tab_b[k].exp_valid) begin
        chk($sformatf("b_op_b%0d", k),  64'(b_op),  64'(tab_b[k].exp_op));
        chk($sformatf("b_end_b%0d", k), 64'(b_end), 64'(tab_b[k].exp_end));
      end
    end
    b_in_valid = 1'b0;
    chk("b_count", 64'(n_out), 64'd9);

    // Two channels, +1 and -1 kernels
    for (int k = 0; k < 29; k++) begin
      c_in_valid = 1'b1;
      c_act      = 16'(k);
      @(posedge clk);
      #1;
      if (k == 27) chk("c_valid_b27", 64'(c_valid), 64'd0);
    end
    c_in_valid = 1'b0;
    chk("c_valid_b28", 64'(c_valid), 64'd1);
    chk("c_ch0", 64'(c_op[31:0]), 64'd350);
`ifdef CONV_RELU_EN
    chk("c_ch1", 64'(c_op[63:32]), 64'd0);
`else
    chk("c_ch1", 64'(c_op[63:32]), 64'hFFFFFEA2);
`endif
    chk("c_end", 64'(c_end), 64'd0);

    @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
